dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Arbitrates the single-ported data memory between the CPU memory stage (s4) and a debug/loader port, so the bench or a debug unit can read and write data memory while the core runs. By default the CPU wins every conflict, and the losing CPU access is reported as a pipeline stall. An optional starvation guard forces one debug grant after a bounded wait. The block sits between the s4 load/store logic and the data memory macro inside `cpu_top`.

## Interface
- `ADDR_W`, 12: word-address width of data memory.
- `MAX_WAIT`, 8: cycles a debug request may be refused before a forced grant; legal range 1..255.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cpu_req` input 1: CPU access request, held until granted.
- `cpu_we` input 1: 1 = store, 0 = load.
- `cpu_addr` input ADDR_W: CPU word address.
- `cpu_wdata` input 32: CPU store data.
- `cpu_be` input 4: CPU byte enables.
- `cpu_gnt` output 1: CPU access issued to memory this cycle.
- `cpu_rvalid` output 1: CPU load data valid.
- `cpu_rdata` output 32: CPU load data.
- `cpu_stall` output 1: `cpu_req & ~cpu_gnt`; freezes s1..s4.
- `dbg_req` input 1: debug access request, held until granted.
- `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_be`: inputs with the same meaning and widths as the CPU fields.
- `dbg_gnt` output 1: debug access issued this cycle.
- `dbg_rvalid` output 1: debug load data valid.
- `dbg_rdata` output 32: debug load data.
- `mem_en` output 1: memory access enable.
- `mem_we` output 4: per-byte write enable, `be & {4{we}}` of the granted requester.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_rdata` input 32: memory read data, valid one cycle after a read with `mem_en=1`.

## Operation
- **Grant logic.** Grant is combinational from requests and state. At most one grant per cycle. The granted requester's fields are muxed onto `mem_*`. `mem_en = cpu_gnt | dbg_gnt`.
- **FSM `CPU_PRI` (reset state).**
  - `cpu_req` → `cpu_gnt`.
  - Otherwise `dbg_req` → `dbg_gnt`.
- **FSM `DBG_FORCE`.**
  - `dbg_req` → `dbg_gnt`, and `cpu_gnt=0` even if `cpu_req=1`.
  - Always returns to `CPU_PRI` next cycle.
- **Wait counter `wait_cnt`, 8 bit.**
  - Increments each cycle that `dbg_req & ~dbg_gnt`.
  - Clears on `dbg_gnt`, and clears when `dbg_req=0`.
  - Saturates at `MAX_WAIT`.
  - When `wait_cnt == MAX_WAIT-1` and debug is refused this cycle: next state `DBG_FORCE`.
- **Dropped debug request.** If `dbg_req` drops while in `DBG_FORCE`, there is no grant that cycle (the CPU may take it), the state returns to `CPU_PRI`, and the counter clears.
- **Read return.**
  - Register `rd_owner` (2 bit: none/cpu/dbg) is loaded on a granted read (`we=0`).
  - Next cycle, `rvalid` of the owner pulses 1, and its `rdata = mem_rdata`.
  - The non-owner `rdata` is held at 0.
- **Writes.** Writes produce no `rvalid`.
- **Back-to-back.** Consecutive grants are allowed every cycle. An `rvalid` can coincide with a new grant.

## Timing
- **Reset values** (while `rst_n=0`):
  - all `gnt`, `rvalid`, `mem_en`, `mem_we` = 0;
  - `mem_addr`, `mem_wdata`, `rdata` = 0;
  - `cpu_stall` = 0;
  - state = `CPU_PRI`, `wait_cnt` = 0, `rd_owner` = none.
- **Reset mid-operation.** A pending `rvalid` is discarded; no `rvalid` occurs after reset release.
- **Latency.**
  - Grant: 0 cycles (same cycle as request, if it wins).
  - Read data: 1 cycle after grant.
  - Write: committed at the grant edge.
- **Worst-case debug wait.** With the guard enabled, a debug request is granted within `MAX_WAIT`+1 cycles of assertion under continuous CPU traffic.
- **CPU stall under force.** The CPU stalls exactly 1 cycle per forced debug grant.
- **Requester obligations.** Requesters must hold fields stable while `req=1` and `gnt=0`; the arbiter does not latch them.

## Configuration
- **`DMEM_ARB_STARVE_GUARD_EN` defined:** `wait_cnt` and `DBG_FORCE` are present, as above.
- **Undefined:**
  - Strict CPU priority; the FSM stays in `CPU_PRI`.
  - No counter logic.
  - `MAX_WAIT` is ignored.
  - Debug can starve indefinitely under continuous CPU traffic.

## Test plan
- **Reset.** Assert `rst_n=0` with both requests high → all outputs 0. Release → a CPU read at addr 0x010 gets `cpu_gnt` the same cycle and `cpu_rvalid` plus `mem_rdata` the next cycle.
- **Debug alone.** Debug write `0xDEADBEEF`, be=0xF, addr 0x020, then debug read 0x020 → `dbg_rvalid` with `0xDEADBEEF` 1 cycle after the read grant; `cpu_rvalid` stays 0.
- **Conflict.** CPU and debug request in the same cycle → `cpu_gnt=1`, `dbg_gnt=0`. Debug is granted the first cycle `cpu_req=0`.
- **Starvation guard** (guard on, `MAX_WAIT`=8). `cpu_req` held high continuously, `dbg_req` high → `dbg_gnt` on cycle 9, `cpu_stall=1` for exactly that cycle, `wait_cnt` back to 0.
- **Guard off.** Same stimulus for 100 cycles → `dbg_gnt` never asserts.
- **Byte-lane write and reset mid-read.**
  - CPU sb with be=0x4, we=1 → `mem_we=0x4`.
  - A read granted, then `rst_n` pulsed low before the next edge → no `rvalid` follows.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-ported data memory between the CPU s4 stage and a
// debug/loader port. The CPU wins every conflict unless the optional starvation guard
// (macro DMEM_ARB_STARVE_GUARD_EN) forces one debug grant after MAX_WAIT refused cycles.
// Grants are combinational; read data returns one cycle after a granted read.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  // Debug / loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_be,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  // Memory macro
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [0:0] {StCpuPri, StDbgForce} state_e;
  typedef enum logic [1:0] {OwnNone = 2'd0, OwnCpu = 2'd1, OwnDbg = 2'd2} owner_e;

  state_e state_q, state_d;
  owner_e rd_owner_q, rd_owner_d;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MaxWait   = 8'(MAX_WAIT);
  localparam logic [7:0] MaxWaitM1 = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       dbg_refused;
`else
  logic       unused_max_wait;
  assign unused_max_wait = ^8'(MAX_WAIT);
`endif

  // Grant selection; held off during reset so nothing reaches memory while rst_n is low
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == StDbgForce && dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = rst_n & cpu_req & ~cpu_gnt;

  // Mux the granted requester onto the memory port; idle bus is driven to zero
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (cpu_gnt) begin
      mem_we    = cpu_be & {4{cpu_we}};
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_be & {4{dbg_we}};
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  assign dbg_refused = dbg_req & ~dbg_gnt;

  // Starvation counter and force decision; a dropped request always clears the count
  always_comb begin
    wait_cnt_d = 8'h0;
    state_d    = StCpuPri;
    if (dbg_refused) begin
      wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 8'd1;
      if (wait_cnt_q == MaxWaitM1) begin
        state_d = StDbgForce;
      end
    end
  end
`else
  // Strict CPU priority: the state never leaves CPU_PRI
  always_comb begin
    state_d = StCpuPri;
  end
`endif

  // Remember who issued the read so the returning data goes to the right port
  always_comb begin
    rd_owner_d = OwnNone;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OwnCpu;
    end else if (dbg_gnt && !dbg_we) begin
      rd_owner_d = OwnDbg;
    end
  end

  // State, read owner and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StCpuPri;
      rd_owner_q <= OwnNone;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      wait_cnt_q <= 8'h0;
`endif
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Read return; the non-owner sees zero data
  always_comb begin
    cpu_rvalid = (rd_owner_q == OwnCpu);
    dbg_rvalid = (rd_owner_q == OwnDbg);
    cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural memory model.
// Runs the starvation-guard scenarios when DMEM_ARB_STARVE_GUARD_EN is defined, otherwise
// the strict-priority starvation scenario.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [11:0] dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_be;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(12), .MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_be     (cpu_be),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_be     (dbg_be),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: preloaded while reset is held, byte-lane writes, registered read data
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[12'h010] <= 32'h1234_5678;
      mem_rdata    <= 32'h0;
    end else if (mem_en) begin
      if (mem_we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010; cpu_wdata = 32'h5555_5555; cpu_be = 4'hF;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h020; dbg_wdata = 32'hAAAA_AAAA; dbg_be = 4'hF;
    repeat (2) @(posedge clk);
    sample();
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid, cpu_stall} !== 10'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b/%b en=%b we=%h rv=%b/%b stall=%b want all 0",
               cpu_gnt, dbg_gnt, mem_en, mem_we, cpu_rvalid, dbg_rvalid, cpu_stall);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 44'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0", cpu_rdata, dbg_rdata);
    end
    // Release with only a CPU read to 0x010 pending
    rst_n = 1'b1;
    dbg_req = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_en, mem_addr} !== {3'b101, 12'h010}) begin
      errors++;
      $display("FAIL rel_cpu_gnt: got gnt=%b/%b en=%b addr=%h want 1/0 1 010",
               cpu_gnt, dbg_gnt, mem_en, mem_addr);
    end
    step();
    cpu_req = 1'b0;
    sample();
    checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {2'b10, 32'h1234_5678}) begin
      errors++;
      $display("FAIL rel_cpu_rdata: got rv=%b/%b data=%h want 1/0 12345678",
               cpu_rvalid, dbg_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_debug_alone();
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h020; dbg_wdata = 32'hDEAD_BEEF; dbg_be = 4'hF;
    sample();
    checks++;
    if ({dbg_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata} !== {2'b10, 4'hF, 12'h020, 32'hDEAD_BEEF})
    begin
      errors++;
      $display("FAIL dbg_write: got gnt=%b/%b we=%h addr=%h wdata=%h want 1/0 F 020 deadbeef",
               dbg_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata);
    end
    step();
    dbg_we = 1'b0;
    sample();
    checks++;
    if ({dbg_gnt, mem_we, dbg_rvalid, cpu_rvalid} !== {1'b1, 4'h0, 2'b00}) begin
      errors++;
      $display("FAIL dbg_read_gnt: got gnt=%b we=%h rv=%b/%b want 1 0 0/0",
               dbg_gnt, mem_we, dbg_rvalid, cpu_rvalid);
    end
    step();
    dbg_req = 1'b0;
    sample();
    checks++;
    if ({dbg_rvalid, cpu_rvalid, dbg_rdata, cpu_rdata} !== {2'b10, 32'hDEAD_BEEF, 32'h0}) begin
      errors++;
      $display("FAIL dbg_rdata: got rv=%b/%b data=%h cpu_data=%h want 1/0 deadbeef 0",
               dbg_rvalid, cpu_rvalid, dbg_rdata, cpu_rdata);
    end
  endtask

  task automatic test_conflict();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h020;
    sample();
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_stall, mem_addr} !== {3'b100, 12'h010}) begin
      errors++;
      $display("FAIL conflict_cpu_wins: got gnt=%b/%b stall=%b addr=%h want 1/0 0 010",
               cpu_gnt, dbg_gnt, cpu_stall, mem_addr);
    end
    step();
    cpu_req = 1'b0;
    sample();
    checks++;
    if ({dbg_gnt, cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr} !==
        {3'b101, 32'h1234_5678, 12'h020}) begin
      errors++;
      $display("FAIL conflict_dbg_b2b: got gnt=%b/%b cpu_rv=%b data=%h addr=%h want 1/0 1 12345678 020",
               dbg_gnt, cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr);
    end
    step();
    dbg_req = 1'b0;
    sample();
    checks++;
    if ({dbg_rvalid, cpu_rvalid, dbg_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL conflict_dbg_rdata: got rv=%b/%b data=%h want 1/0 deadbeef",
               dbg_rvalid, cpu_rvalid, dbg_rdata);
    end
  endtask

`ifdef DMEM_ARB_STARVE_GUARD_EN
  task automatic test_guard();
    logic exp;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h020;
    for (int c = 1; c <= 18; c++) begin
      sample();
      exp = (c == 9) || (c == 18);
      checks++;
      if ({dbg_gnt, cpu_gnt, cpu_stall} !== {exp, ~exp, exp}) begin
        errors++;
        $display("FAIL guard_cycle%0d: got dbg_gnt=%b cpu_gnt=%b stall=%b want %b %b %b",
                 c, dbg_gnt, cpu_gnt, cpu_stall, exp, ~exp, exp);
      end
      if (c >= 2) begin
        checks++;
        if ({cpu_rvalid, dbg_rvalid} !== {(c != 10), (c == 10)}) begin
          errors++;
          $display("FAIL guard_rvalid%0d: got %b/%b want %b/%b",
                   c, cpu_rvalid, dbg_rvalid, (c != 10), (c == 10));
        end
      end
      step();
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    sample();
    checks++;
    if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL guard_dbg_rdata: got rv=%b data=%h want 1 deadbeef", dbg_rvalid, dbg_rdata);
    end
  endtask

  task automatic test_guard_drop();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h020;
    for (int c = 1; c <= 8; c++) begin
      sample();
      checks++;
      if (dbg_gnt !== 1'b0) begin
        errors++;
        $display("FAIL drop_pre%0d: got dbg_gnt=%b want 0", c, dbg_gnt);
      end
      step();
    end
    dbg_req = 1'b0;
    sample();
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_stall} !== 3'b100) begin
      errors++;
      $display("FAIL drop_force: got gnt=%b/%b stall=%b want 1/0 0", cpu_gnt, dbg_gnt, cpu_stall);
    end
    step();
    dbg_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      sample();
      checks++;
      if (dbg_gnt !== (c == 9)) begin
        errors++;
        $display("FAIL drop_rearm%0d: got dbg_gnt=%b want %b", c, dbg_gnt, (c == 9));
      end
      step();
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask
`else
  task automatic test_guard_off();
    int n_dbg = 0;
    int n_nostall = 0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h020;
    for (int c = 0; c < 100; c++) begin
      sample();
      if (dbg_gnt) n_dbg++;
      if (cpu_stall || !cpu_gnt) n_nostall++;
      step();
    end
    checks++;
    if (n_dbg !== 0) begin
      errors++;
      $display("FAIL guard_off_dbg_gnt: got %0d grants want 0", n_dbg);
    end
    checks++;
    if (n_nostall !== 0) begin
      errors++;
      $display("FAIL guard_off_cpu: got %0d stalled cycles want 0", n_nostall);
    end
    cpu_req = 1'b0;
    sample();
    checks++;
    if ({dbg_gnt, cpu_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL guard_off_release: got gnt=%b/%b want 1/0", dbg_gnt, cpu_gnt);
    end
    step();
    dbg_req = 1'b0;
  endtask
`endif

  task automatic test_byte_lane();
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'h4; cpu_addr = 12'h030; cpu_wdata = 32'hAABB_CCDD;
    dbg_req = 1'b0;
    sample();
    checks++;
    if ({cpu_gnt, mem_en, mem_we, mem_wdata} !== {2'b11, 4'h4, 32'hAABB_CCDD}) begin
      errors++;
      $display("FAIL sb_mem_we: got gnt=%b en=%b we=%h wdata=%h want 1 1 4 aabbccdd",
               cpu_gnt, mem_en, mem_we, mem_wdata);
    end
    step();
    cpu_we = 1'b0; cpu_be = 4'hF;
    sample();
    checks++;
    if ({cpu_rvalid, dbg_rvalid, mem_we} !== 6'h0) begin
      errors++;
      $display("FAIL sb_no_rvalid: got rv=%b/%b we=%h want 0/0 0", cpu_rvalid, dbg_rvalid, mem_we);
    end
    step();
    cpu_req = 1'b0;
    sample();
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h00BB_0000}) begin
      errors++;
      $display("FAIL sb_readback: got rv=%b data=%h want 1 00bb0000", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    sample();
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt: got %b want 1", cpu_gnt);
    end
    step();
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sample();
    checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL midrst_rvalid: got rv=%b/%b data=%h want 0/0 0", cpu_rvalid, dbg_rvalid,
               cpu_rdata);
    end
    step();
    sample();
    checks++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_after: got rv=%b/%b want 0/0", cpu_rvalid, dbg_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_debug_alone();
    test_conflict();
`ifdef DMEM_ARB_STARVE_GUARD_EN
    test_guard();
    test_guard_drop();
`else
    test_guard_off();
`endif
    test_byte_lane();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
